// File: rtl/apb_traffic_pkg.sv
// Shared definitions for the APB traffic-light controller: FSM state
// encoding, light encodings, register byte offsets and the per-direction
// light decode helper.
package apb_traffic_pkg;

    // Encoding is visible to software through STATUS[2:0].
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GREEN     = 3'd1,
        ST_YELLOW    = 3'd2,
        ST_ALLRED    = 3'd3,
        ST_FLASH_ON  = 3'd4,
        ST_FLASH_OFF = 3'd5
    } tl_state_e;

    // Two bits per direction on light_o.
    localparam logic [1:0] LIGHT_OFF    = 2'b00;
    localparam logic [1:0] LIGHT_RED    = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    // Register byte offsets; address bits [1:0] are ignored by the decoder.
    localparam logic [11:0] REG_CTRL        = 12'h000;
    localparam logic [11:0] REG_GREEN_TIME  = 12'h004;
    localparam logic [11:0] REG_YELLOW_TIME = 12'h008;
    localparam logic [11:0] REG_STATUS      = 12'h00C;
    localparam logic [11:0] REG_INT_STAT    = 12'h010;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLASH_BIT = 1;
    localparam int CTRL_INTEN_BIT = 2;

    // Light shown by one direction given the FSM state and whether that
    // direction currently owns the right of way.
    function automatic logic [1:0] light_for(input tl_state_e st, input logic is_active);
        logic [1:0] lt;
        lt = LIGHT_RED;
        case (st)
            ST_GREEN:     lt = is_active ? LIGHT_GREEN : LIGHT_RED;
            ST_YELLOW:    lt = is_active ? LIGHT_YELLOW : LIGHT_RED;
            ST_FLASH_ON:  lt = LIGHT_YELLOW;
            ST_FLASH_OFF: lt = LIGHT_OFF;
            default:      lt = LIGHT_RED;
        endcase
        return lt;
    endfunction

endpackage

// File: rtl/apb_traffic_ctrl_if.sv
// APB slave bus bundle for the traffic-light controller. Clock and reset
// stay as plain ports on the modules that use this interface.
interface apb_traffic_ctrl_if;

    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/tl_phase_timer.sv
// Loadable down-counter timing one traffic phase. A load of 0 is stored as
// 1 so every phase lasts at least one cycle; o_expire flags the final cycle
// of the phase (count == 1), which is when the FSM moves on.
module tl_phase_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_clear,
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_count;

    // Clear beats load beats decrement; the counter parks at zero when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_load_val == '0) ? TIMER_W'(1) : i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_expire = (r_count == TIMER_W'(1));

endmodule

// File: rtl/apb_traffic_ctrl.sv
// APB-programmable traffic-light controller. Cycles each direction through
// green / yellow / all-red, or flashes all directions yellow, with phase
// lengths taken from software-visible timer registers.
module apb_traffic_ctrl
    import apb_traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int TIMER_W    = 32,
    parameter int ALLRED_CYC = 4
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_traffic_ctrl_if.slave    apb,
    output logic [2*NUM_DIR-1:0] light_o,
    output logic                 irq
);

    // ------------------------------------------------------------------
    // Register and state storage
    // ------------------------------------------------------------------
    logic [2:0]         r_ctrl;
    logic [TIMER_W-1:0] r_green_time;
    logic [TIMER_W-1:0] r_yellow_time;
    logic               r_int_stat;
    tl_state_e          r_state;
    logic [1:0]         r_dir;
    logic [2*NUM_DIR-1:0] r_light;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic [11:0] w_addr_word;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_hit_ctrl;
    logic        w_hit_green;
    logic        w_hit_yellow;
    logic        w_hit_status;
    logic        w_hit_int;
    logic        w_mapped;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_addr_word  = {apb.paddr[11:2], 2'b00};
    assign w_unused     = &{1'b0, apb.paddr[1:0]};

    // Bus outputs are held quiet while reset is asserted.
    assign w_access     = presetn & apb.psel & apb.penable;
    assign w_wr         = w_access & apb.pwrite;
    assign w_rd         = w_access & ~apb.pwrite;

    assign w_hit_ctrl   = (w_addr_word == REG_CTRL);
    assign w_hit_green  = (w_addr_word == REG_GREEN_TIME);
    assign w_hit_yellow = (w_addr_word == REG_YELLOW_TIME);
    assign w_hit_status = (w_addr_word == REG_STATUS);
    assign w_hit_int    = (w_addr_word == REG_INT_STAT);
    assign w_mapped     = w_hit_ctrl | w_hit_green | w_hit_yellow | w_hit_status | w_hit_int;

    // STATUS is read-only, so a write there is as erroneous as an unmapped one.
    assign apb.pslverr  = w_access & (~w_mapped | (apb.pwrite & w_hit_status));
    assign apb.pready   = 1'b1;

    // Read data straight from current register values; zero outside a read access.
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_addr_word)
                REG_CTRL:        w_rdata[2:0]         = r_ctrl;
                REG_GREEN_TIME:  w_rdata[TIMER_W-1:0] = r_green_time;
                REG_YELLOW_TIME: w_rdata[TIMER_W-1:0] = r_yellow_time;
                REG_STATUS: begin
                    w_rdata[2:0] = r_state;
                    w_rdata[5:4] = r_dir;
                end
                REG_INT_STAT:    w_rdata[0]           = r_int_stat;
                default:         w_rdata              = '0;
            endcase
        end
    end

    assign apb.prdata = w_rdata;

    // Software-writable configuration registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ctrl        <= '0;
            r_green_time  <= TIMER_W'(10);
            r_yellow_time <= TIMER_W'(3);
        end else if (w_wr) begin
            if (w_hit_ctrl)   r_ctrl        <= apb.pwdata[2:0];
            if (w_hit_green)  r_green_time  <= apb.pwdata[TIMER_W-1:0];
            if (w_hit_yellow) r_yellow_time <= apb.pwdata[TIMER_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    logic               w_en;
    logic               w_flash;
    logic               w_expire;
    tl_state_e          w_state_next;
    logic [1:0]         w_dir_next;
    logic [1:0]         w_dir_inc;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_clear;
    logic               w_set_done;

    assign w_en      = r_ctrl[CTRL_EN_BIT];
    assign w_flash   = r_ctrl[CTRL_FLASH_BIT];
    assign w_dir_inc = (r_dir == 2'(NUM_DIR - 1)) ? 2'd0 : r_dir + 2'd1;

    // Next state, next direction and timer load; every state change reloads the timer.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_clear      = 1'b0;
        w_set_done   = 1'b0;
        if (!w_en) begin
            // Disabling abandons the running phase immediately.
            if (r_state != ST_IDLE) begin
                w_state_next = ST_IDLE;
                w_dir_next   = 2'd0;
                w_clear      = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_load = 1'b1;
                    if (w_flash) begin
                        w_state_next = ST_FLASH_ON;
                        w_load_val   = r_yellow_time;
                    end else begin
                        w_state_next = ST_GREEN;
                        w_dir_next   = 2'd0;
                        w_load_val   = r_green_time;
                    end
                end
                ST_GREEN: begin
                    if (w_expire) begin
                        w_state_next = ST_YELLOW;
                        w_load       = 1'b1;
                        w_load_val   = r_yellow_time;
                    end
                end
                ST_YELLOW: begin
                    if (w_expire) begin
                        w_state_next = ST_ALLRED;
                        w_load       = 1'b1;
                        w_load_val   = TIMER_W'(ALLRED_CYC);
                    end
                end
                ST_ALLRED: begin
                    if (w_expire) begin
                        w_load     = 1'b1;
                        w_set_done = (r_dir == 2'(NUM_DIR - 1));
                        // A mode change requested mid-cycle is honoured only here.
                        if (w_flash) begin
                            w_state_next = ST_FLASH_ON;
                            w_dir_next   = 2'd0;
                            w_load_val   = r_yellow_time;
                        end else begin
                            w_state_next = ST_GREEN;
                            w_dir_next   = w_dir_inc;
                            w_load_val   = r_green_time;
                        end
                    end
                end
                ST_FLASH_ON, ST_FLASH_OFF: begin
                    if (w_expire) begin
                        w_load = 1'b1;
                        if (!w_flash) begin
                            // Leave flash mode through a clearance interval.
                            w_state_next = ST_ALLRED;
                            w_dir_next   = 2'd0;
                            w_load_val   = TIMER_W'(ALLRED_CYC);
                        end else begin
                            w_state_next = (r_state == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
                            w_load_val   = r_yellow_time;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_dir_next   = 2'd0;
                    w_clear      = 1'b1;
                end
            endcase
        end
    end

    // State and active-direction registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
            r_dir   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
        end
    end

    tl_phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .i_clk      (pclk),
        .i_rst_n    (presetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_clear    (w_clear),
        .o_expire   (w_expire)
    );

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    logic w_clr_done;
    assign w_clr_done = w_wr & w_hit_int & apb.pwdata[0];

    // cycle_done: hardware set has priority over a simultaneous W1C.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_int_stat <= 1'b0;
        end else if (w_set_done) begin
            r_int_stat <= 1'b1;
        end else if (w_clr_done) begin
            r_int_stat <= 1'b0;
        end
    end

    assign irq = r_int_stat & r_ctrl[CTRL_INTEN_BIT];

    // ------------------------------------------------------------------
    // Lights: decoded from the next state so they change with the state
    // and come straight from flops.
    // ------------------------------------------------------------------
    logic [2*NUM_DIR-1:0] w_light_next;

    generate
        for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_light
            assign w_light_next[gi*2 +: 2] = light_for(w_state_next, w_dir_next == 2'(gi));
        end
    endgenerate

    // Light output register, all red out of reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_light <= {NUM_DIR{LIGHT_RED}};
        end else begin
            r_light <= w_light_next;
        end
    end

    assign light_o = r_light;

endmodule
